// File: rtl/code_setter_if.sv
// Button, switch and status bundle between the code programmer and its user side.
interface code_setter_if #(
  parameter int CODE_W = 4
);
  logic              change;
  logic              enter;
  logic              oops;
  logic [CODE_W-1:0] login;
  logic [CODE_W-1:0] passw;
  logic              busy;
  logic              updated;
  logic [3:0]        flag;

  modport slave (
    input  change, enter, oops, login,
    output passw, busy, updated, flag
  );

  modport master (
    output change, enter, oops, login,
    input  passw, busy, updated, flag
  );
endinterface

// File: rtl/code_setter.sv
// Stored-code register with authenticate / enter / confirm programming sequence.
// Optional lockout after MAX_TRIES failed authentications: define CODE_SETTER_LOCKOUT_EN.
module code_setter #(
  parameter int                 CODE_W       = 4,
  parameter logic [CODE_W-1:0]  DEFAULT_CODE = 4'b1001,
  parameter int                 MAX_TRIES    = 3
) (
  input logic         clk,
  input logic         reset,
  code_setter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AUTH   = 3'd1,
    S_NEW1   = 3'd2,
    S_NEW2   = 3'd3,
    S_DONE   = 3'd4,
    S_LOCKED = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] passw_q, passw_d;
  logic [CODE_W-1:0] new_q, new_d;
  logic              updated_q, updated_d;
  logic              busy_q, busy_d;
  logic [3:0]        flag_q, flag_d;
  logic              change_q, enter_q, oops_q;
  logic              oops_ev, enter_ev, change_ev;

`ifdef CODE_SETTER_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  logic [FAIL_W-1:0] fail_q, fail_d;
`endif

  // Rising-edge events with oops > enter > change priority.
  assign oops_ev   = bus.oops & ~oops_q;
  assign enter_ev  = bus.enter & ~enter_q & ~oops_ev;
  assign change_ev = bus.change & ~change_q & ~oops_ev & ~(bus.enter & ~enter_q);

  always_comb begin
    state_d   = state_q;
    passw_d   = passw_q;
    new_d     = new_q;
    updated_d = 1'b0;
`ifdef CODE_SETTER_LOCKOUT_EN
    fail_d    = fail_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (change_ev) state_d = S_AUTH;
        else           state_d = S_IDLE;
      end
      S_AUTH: begin
        if (oops_ev) begin
          state_d = S_IDLE;
          new_d   = '0;
        end else if (enter_ev) begin
          if (bus.login == passw_q) begin
            state_d = S_NEW1;
`ifdef CODE_SETTER_LOCKOUT_EN
            fail_d  = '0;
`endif
          end else begin
            state_d = S_AUTH;
`ifdef CODE_SETTER_LOCKOUT_EN
            if (fail_q != FAIL_W'(MAX_TRIES)) fail_d = fail_q + {{(FAIL_W-1){1'b0}}, 1'b1};
            else                              fail_d = fail_q;
            if (fail_d == FAIL_W'(MAX_TRIES)) state_d = S_LOCKED;
            else                              state_d = S_AUTH;
`endif
          end
        end else begin
          state_d = S_AUTH;
        end
      end
      S_NEW1: begin
        if (oops_ev) begin
          state_d = S_IDLE;
          new_d   = '0;
        end else if (enter_ev) begin
          new_d   = bus.login;
          state_d = S_NEW2;
        end else begin
          state_d = S_NEW1;
        end
      end
      S_NEW2: begin
        if (oops_ev) begin
          state_d = S_IDLE;
          new_d   = '0;
        end else if (enter_ev) begin
          if (bus.login == new_q) state_d = S_DONE;
          else                    state_d = S_NEW1;
        end else begin
          state_d = S_NEW2;
        end
      end
      // The commit cycle always completes; an abort here would arrive too late.
      S_DONE: begin
        passw_d   = new_q;
        updated_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_LOCKED: state_d = S_LOCKED;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:   flag_d = 4'b0000;
      S_AUTH:   flag_d = 4'b0001;
      S_NEW1:   flag_d = 4'b0010;
      S_NEW2:   flag_d = 4'b0100;
      S_DONE:   flag_d = 4'b1000;
      S_LOCKED: flag_d = 4'b1111;
      default:  flag_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      passw_q   <= DEFAULT_CODE;
      new_q     <= '0;
      updated_q <= 1'b0;
      busy_q    <= 1'b0;
      flag_q    <= 4'b0000;
      change_q  <= 1'b0;
      enter_q   <= 1'b0;
      oops_q    <= 1'b0;
`ifdef CODE_SETTER_LOCKOUT_EN
      fail_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      passw_q   <= passw_d;
      new_q     <= new_d;
      updated_q <= updated_d;
      busy_q    <= busy_d;
      flag_q    <= flag_d;
      change_q  <= bus.change;
      enter_q   <= bus.enter;
      oops_q    <= bus.oops;
`ifdef CODE_SETTER_LOCKOUT_EN
      fail_q    <= fail_d;
`endif
    end
  end

  assign bus.passw   = passw_q;
  assign bus.busy    = busy_q;
  assign bus.updated = updated_q;
  assign bus.flag    = flag_q;

endmodule
